// File: rtl/regex_sched_pkg.sv
// Shared definitions for the regex PC scheduler.
// Holds the scheduler state encoding and the string terminator value.
package regex_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    RUN,
    EVAL,
    DONE
  } sched_state_t;

  // Terminator character; cast to CHARACTER_WIDTH by the user.
  localparam int unsigned TERMINATOR_VALUE = 0;

endpackage

// File: rtl/regex_pc_fifo.sv
// Synchronous PC queue used for the current and next thread lists.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           empties the queue; a same-cycle push lands in the emptied queue
//   push, push_data write one entry (caller guarantees space, or a same-cycle pop)
//   pop             drop the head entry (caller guarantees not empty)
//   data_out        head entry
//   count           number of stored entries (DEPTH_LOG2+1 bits)
//   empty, full     count == 0, count == depth
module regex_pc_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      data_out,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [Depth];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] wr_addr;

  assign wr_addr  = flush ? '0 : wr_ptr;
  assign data_out = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CntW'(Depth));

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= DEPTH_LOG2'(push);
      count  <= CntW'(push);
    end else begin
      if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_addr] <= push_data;
  end

endmodule

// File: rtl/regex_pc_scheduler.sv
// Thread scheduler for the pipelined regex CPU.
// Feeds PCs from the current-character queue to the CPU, routes continuation PCs into the
// current or next queue (with optional duplicate suppression), steps through the input
// string and reports accept/reject.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   start, start_pc                    begin a match at start_pc (IDLE or DONE only)
//   char_in_valid/char_in/char_in_ready  input string, 0 terminates
//   current_character                  character under evaluation
//   cpu_pc_valid/cpu_pc/cpu_pc_ready   PC dispatch to the CPU
//   cpu_out_pc_*                       continuation PCs from the CPU
//   cpu_accepts, cpu_running           CPU status
//   busy, done, accepted, overflow     status / result
//   char_count                         characters consumed, saturating
module regex_pc_scheduler
  import regex_sched_pkg::*;
#(
  parameter int unsigned PC_WIDTH              = 8,
  parameter int unsigned CHARACTER_WIDTH       = 8,
  parameter int unsigned FIFO_DEPTH_POWER_OF_2 = 4,
  parameter bit          DEDUP                 = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [PC_WIDTH-1:0]        start_pc,
  input  logic                       char_in_valid,
  input  logic [CHARACTER_WIDTH-1:0] char_in,
  output logic                       char_in_ready,
  output logic [CHARACTER_WIDTH-1:0] current_character,
  output logic                       cpu_pc_valid,
  output logic [PC_WIDTH-1:0]        cpu_pc,
  input  logic                       cpu_pc_ready,
  input  logic                       cpu_out_pc_valid,
  input  logic [PC_WIDTH-1:0]        cpu_out_pc,
  input  logic                       cpu_out_pc_is_directed_to_current,
  output logic                       cpu_out_pc_ready,
  input  logic                       cpu_accepts,
  input  logic                       cpu_running,
  output logic                       busy,
  output logic                       done,
  output logic                       accepted,
  output logic                       overflow,
  output logic [15:0]                char_count
);

  localparam int unsigned NumPcs = 1 << PC_WIDTH;
  localparam logic [CHARACTER_WIDTH-1:0] Terminator = CHARACTER_WIDTH'(TERMINATOR_VALUE);

  sched_state_t state_q, state_d;
  logic cur_sel_q, cur_sel_d;
  logic accept_flag_q, accept_flag_d;
  logic overflow_q, overflow_d;
  logic accepted_q, accepted_d;
  logic [CHARACTER_WIDTH-1:0] char_q, char_d;
  logic [15:0] char_count_q, char_count_d;
  logic [NumPcs-1:0] bitmap_q [2];
  logic [NumPcs-1:0] bitmap_d [2];

  logic [1:0] q_push, q_pop, q_empty, q_full;
  logic q_flush;
  logic [PC_WIDTH-1:0] q_data [2];
  logic [PC_WIDTH-1:0] q_head [2];
  logic [FIFO_DEPTH_POWER_OF_2:0] q_count [2];

  for (genvar i = 0; i < 2; i++) begin : g_queue
    regex_pc_fifo #(
      .WIDTH      (PC_WIDTH),
      .DEPTH_LOG2 (FIFO_DEPTH_POWER_OF_2)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (q_flush),
      .push      (q_push[i]),
      .push_data (q_data[i]),
      .pop       (q_pop[i]),
      .data_out  (q_head[i]),
      .count     (q_count[i]),
      .empty     (q_empty[i]),
      .full      (q_full[i])
    );
  end

  // Occupancy counts are only of interest when probing the queues.
  logic unused_count;
  assign unused_count = ^{q_count[0], q_count[1]};

  logic dispatch, target, is_dup, target_full, take_cont;

  assign cpu_pc_valid     = (state_q == RUN) && !q_empty[cur_sel_q] && !accept_flag_q;
  assign cpu_pc           = cpu_pc_valid ? q_head[cur_sel_q] : '0;
  assign dispatch         = cpu_pc_valid && cpu_pc_ready;
  // Never back-pressure the CPU: a stalled continuation can deadlock its pipeline.
  assign cpu_out_pc_ready = (state_q == RUN);
  assign target           = cpu_out_pc_is_directed_to_current ? cur_sel_q : ~cur_sel_q;
  // After an accept, continuations are swallowed without touching the queues.
  assign take_cont        = cpu_out_pc_valid && (state_q == RUN) && !accept_flag_q;
  assign is_dup           = DEDUP && bitmap_q[target][cpu_out_pc];
  // A same-cycle pop frees a slot when pushing back into the current queue.
  assign target_full      = q_full[target] && !(dispatch && (target == cur_sel_q));

  assign char_in_ready     = (state_q == FETCH);
  assign busy              = (state_q == FETCH) || (state_q == RUN) || (state_q == EVAL);
  assign done              = (state_q == DONE);
  assign accepted          = accepted_q;
  assign overflow          = overflow_q;
  assign current_character = char_q;
  assign char_count        = char_count_q;

  always_comb begin
    state_d       = state_q;
    cur_sel_d     = cur_sel_q;
    accept_flag_d = accept_flag_q;
    overflow_d    = overflow_q;
    accepted_d    = accepted_q;
    char_d        = char_q;
    char_count_d  = char_count_q;
    bitmap_d      = bitmap_q;
    q_push        = '0;
    q_pop         = '0;
    q_flush       = 1'b0;
    q_data[0]     = '0;
    q_data[1]     = '0;

    q_pop[cur_sel_q] = dispatch;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          q_flush             = 1'b1;
          bitmap_d[0]         = '0;
          bitmap_d[1]         = '0;
          q_push[cur_sel_q]   = 1'b1;
          q_data[cur_sel_q]   = start_pc;
          bitmap_d[cur_sel_q][start_pc] = 1'b1;
          accept_flag_d       = 1'b0;
          overflow_d          = 1'b0;
          accepted_d          = 1'b0;
          char_count_d        = '0;
          state_d             = FETCH;
        end
      end
      FETCH: begin
        if (char_in_valid) begin
          char_d = char_in;
          if (char_count_q != 16'hFFFF) char_count_d = char_count_q + 16'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cpu_accepts) accept_flag_d = 1'b1;
        if (take_cont && !is_dup) begin
          if (target_full) begin
            overflow_d = 1'b1;
          end else begin
            q_push[target]               = 1'b1;
            q_data[target]               = cpu_out_pc;
            bitmap_d[target][cpu_out_pc] = 1'b1;
          end
        end
        // Once accepted, leftover queued PCs are irrelevant; only wait for the pipe to drain.
        if ((q_empty[cur_sel_q] || accept_flag_q) && !cpu_running && !cpu_out_pc_valid) begin
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (accept_flag_q) begin
          accepted_d = 1'b1;
          state_d    = DONE;
        end else if (char_q == Terminator || q_empty[~cur_sel_q]) begin
          accepted_d = 1'b0;
          state_d    = DONE;
        end else begin
          bitmap_d[cur_sel_q] = '0;
          cur_sel_d           = ~cur_sel_q;
          state_d             = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cur_sel_q     <= 1'b0;
      accept_flag_q <= 1'b0;
      overflow_q    <= 1'b0;
      accepted_q    <= 1'b0;
      char_q        <= '0;
      char_count_q  <= '0;
      bitmap_q[0]   <= '0;
      bitmap_q[1]   <= '0;
    end else begin
      state_q       <= state_d;
      cur_sel_q     <= cur_sel_d;
      accept_flag_q <= accept_flag_d;
      overflow_q    <= overflow_d;
      accepted_q    <= accepted_d;
      char_q        <= char_d;
      char_count_q  <= char_count_d;
      bitmap_q      <= bitmap_d;
    end
  end

endmodule
